// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: valid/ready command in, one bus transfer, valid/ready response out.
// Optional build macro AHB_MST_ALIGN_CHECK_EN rejects oversized or misaligned commands without touching the bus.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL  = 4'b0011,
    parameter int         DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [31:0]           r_haddr;
    logic [1:0]            r_htrans;
    logic                  r_hwrite;
    logic [2:0]            r_hsize;
    logic [DATA_WIDTH-1:0] r_hwdata;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err_sticky;

    logic w_cmd_hs;
    logic w_reject;
    logic w_err_now;

    // cmd_ready is only ever high in IDLE, so it alone qualifies the handshake.
    assign w_cmd_hs  = cmd_valid & r_cmd_ready;
    assign w_err_now = r_err_sticky | HRESP;

`ifdef AHB_MST_ALIGN_CHECK_EN
    logic w_misaligned;
    always_comb begin
        w_misaligned = 1'b0;
        if (cmd_size > 3'd2)
            w_misaligned = 1'b1;
        else if (cmd_size == 3'd1)
            w_misaligned = cmd_addr[0];
        else if (cmd_size == 3'd2)
            w_misaligned = (cmd_addr[1:0] != 2'b00);
    end
    assign w_reject = w_misaligned;
`else
    assign w_reject = 1'b0;
`endif

    // NOTE: every register here uses <= so all state updates see pre-edge values, and all are async reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
            r_haddr      <= '0;
            r_htrans     <= HTRANS_IDLE;
            r_hwrite     <= 1'b0;
            r_hsize      <= '0;
            r_hwdata     <= '0;
            r_wdata      <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_hs) begin
                        r_cmd_ready <= 1'b0;
                        if (w_reject) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_haddr  <= cmd_addr;
                            r_hsize  <= cmd_size;
                            r_hwrite <= cmd_write;
                            r_wdata  <= cmd_wdata;
                            r_htrans <= HTRANS_NONSEQ;
                            r_state  <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        r_htrans     <= HTRANS_IDLE;
                        r_err_sticky <= 1'b0;
                        if (r_hwrite)
                            r_hwdata <= r_wdata;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_err    <= w_err_now;
                        r_rsp_rdata  <= (!r_hwrite && !w_err_now) ? HRDATA : '0;
                        r_err_sticky <= 1'b0;
                        r_state      <= S_RESP;
                    end else if (HRESP) begin
                        // Remember the first half of a two-cycle ERROR response.
                        r_err_sticky <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign HADDR     = r_haddr;
    assign HTRANS    = r_htrans;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HWDATA    = r_hwdata;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;

endmodule
